// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator. Divides the system clock to the pixel rate,
// walks the (row, column) raster and produces registered sync, display-enable
// and pixel/frame strobes, all updated on the same edge as the counters.
module vga_sync #(
   parameter int C_SIZE    = 9,
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   output logic [C_SIZE:0] row,
   output logic [C_SIZE:0] column,
   output logic            disp_enable,
   output logic            hsync,
   output logic            vsync,
   output logic            pix_tick,
   output logic            frame_start
);

   localparam int CW      = C_SIZE + 1;
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [C_SIZE:0]  H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [C_SIZE:0]  V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [C_SIZE:0]  H_VIS    = CW'(H_VISIBLE);
   localparam logic [C_SIZE:0]  V_VIS    = CW'(V_VISIBLE);
   localparam logic [C_SIZE:0]  HS_START = CW'(H_VISIBLE + H_FRONT);
   localparam logic [C_SIZE:0]  HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [C_SIZE:0]  VS_START = CW'(V_VISIBLE + V_FRONT);
   localparam logic [C_SIZE:0]  VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div;
   logic             advance;
   logic [C_SIZE:0]  col_nxt;
   logic [C_SIZE:0]  row_nxt;
   logic             de_nxt;
   logic             hs_act;
   logic             vs_act;
   logic             origin_nxt;

   // Next raster position and the decoded output levels at that position.
   always_comb begin
      advance = (div == DIV_LAST);
      col_nxt = column + 1'b1;
      row_nxt = row;
      if (column == H_LAST) begin
         col_nxt = '0;
         row_nxt = (row == V_LAST) ? '0 : row + 1'b1;
      end
      de_nxt     = (col_nxt < H_VIS) && (row_nxt < V_VIS);
      hs_act     = (col_nxt >= HS_START) && (col_nxt < HS_END);
      vs_act     = (row_nxt >= VS_START) && (row_nxt < VS_END);
      origin_nxt = (col_nxt == '0) && (row_nxt == '0);
   end

   // Divider, raster counters and registered outputs share one edge, so no skew.
   // Reset parks the raster on the last pixel so the first advance lands on (0,0).
   always_ff @(posedge clock) begin
      if (reset) begin
         div         <= '0;
         column      <= H_LAST;
         row         <= V_LAST;
         disp_enable <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= advance ? '0 : div + 1'b1;
         pix_tick    <= advance;
         frame_start <= advance && origin_nxt;
         if (advance) begin
            column      <= col_nxt;
            row         <= row_nxt;
            disp_enable <= de_nxt;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

endmodule
